half_adder: RTL and testbench

HALF_ADDER -- requirements
Module: half_adder

---
 rtl/half_adder_pkg.sv | 12 +
 rtl/half_adder_if.sv | 35 +++
 rtl/half_adder_bit.sv | 13 +
 rtl/half_adder.sv | 91 +++++++++
 tb/tb_half_adder.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/half_adder_pkg.sv
// rtl/half_adder_pkg.sv - shared limits and counter helpers for half_adder
package half_adder_pkg;

  localparam int MAX_WIDTH = 64;
  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/half_adder_if.sv
// rtl/half_adder_if.sv - operand/result bundle for half_adder
// carry_count exists only when HALF_ADDER_STATS_EN is defined.
interface half_adder_if
  import half_adder_pkg::*;
#(
  parameter int WIDTH = 1
);

  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic [WIDTH-1:0] sum;
  logic             carry;
`ifdef HALF_ADDER_STATS_EN
  logic [CNT_W-1:0] carry_count;
`endif

  modport master (
    output in_valid, a, b,
`ifdef HALF_ADDER_STATS_EN
    input  carry_count,
`endif
    input  out_valid, sum, carry
  );

  modport slave (
    input  in_valid, a, b,
`ifdef HALF_ADDER_STATS_EN
    output carry_count,
`endif
    output out_valid, sum, carry
  );

endinterface

// File: rtl/half_adder_bit.sv
// rtl/half_adder_bit.sv - one ripple stage: sum and majority carry
module half_adder_bit (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/half_adder.sv
// rtl/half_adder.sv - WIDTH-bit ripple adder, optional output register
// Optional saturating carry counter enabled by HALF_ADDER_STATS_EN.
module half_adder
  import half_adder_pkg::*;
#(
  parameter int WIDTH   = 1,
  parameter bit REG_OUT = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  half_adder_if.slave  bus
);

  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("half_adder: WIDTH=%0d outside 1..%0d", WIDTH, MAX_WIDTH);
  end

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum_d;
  logic             carry_d;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    half_adder_bit u_bit (
      .x  (bus.a[i]),
      .y  (bus.b[i]),
      .ci (c[i]),
      .s  (sum_d[i]),
      .co (c[i+1])
    );
  end

  assign carry_d = c[WIDTH];

  if (REG_OUT) begin : g_reg
    logic             valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;

    // Results only update on valid input so an idle cycle keeps the last answer visible.
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        sum_q   <= '0;
        carry_q <= 1'b0;
      end else begin
        valid_q <= bus.in_valid;
        if (bus.in_valid) begin
          sum_q   <= sum_d;
          carry_q <= carry_d;
        end
      end
    end

    assign bus.out_valid = valid_q;
    assign bus.sum       = sum_q;
    assign bus.carry     = carry_q;
  end else begin : g_comb
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    assign bus.out_valid = bus.in_valid;
    assign bus.sum       = sum_d;
    assign bus.carry     = carry_d;
  end

`ifdef HALF_ADDER_STATS_EN
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (bus.in_valid && carry_d) begin
      cnt_d = sat_inc(cnt_q);
    end
  end

  // Reset wins over a coincident valid pair, so that pair is never counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.carry_count = cnt_q;
`endif

endmodule

// File: tb/tb_half_adder.sv
// tb/tb_half_adder.sv - table and scoreboard checks for half_adder
module tb_half_adder;

  logic clk;
  logic rst1;
  logic rst8;
  logic rst64;

  int n_checks;
  int n_err;

  half_adder_if #(.WIDTH(1))  if1 ();
  half_adder_if #(.WIDTH(8))  if8 ();
  half_adder_if #(.WIDTH(64)) if64 ();

  half_adder #(.WIDTH(1), .REG_OUT(1'b0)) u_dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (if1.slave)
  );

  half_adder #(.WIDTH(8), .REG_OUT(1'b1)) u_dut8 (
    .clk (clk),
    .rst (rst8),
    .bus (if8.slave)
  );

  half_adder #(.WIDTH(64), .REG_OUT(1'b1)) u_dut64 (
    .clk (clk),
    .rst (rst64),
    .bus (if64.slave)
  );

  typedef struct {
    logic a;
    logic b;
    logic v;
    logic s;
    logic c;
  } vec1_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] s;
    logic       c;
  } vec8_t;

  typedef struct packed {
    logic [7:0] s;
    logic       c;
  } res8_t;

  vec1_t       t1[8];
  vec8_t       t8[6];
  res8_t       sb8[$];
  logic [64:0] sb64[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pop8(input string name);
    res8_t r;
    check({name, "_valid"}, 65'(if8.out_valid), 65'd1);
    if (sb8.size() == 0) begin
      check({name, "_sb_empty"}, 65'd1, 65'd0);
    end else begin
      r = sb8.pop_front();
      check({name, "_sum"}, 65'(if8.sum), 65'(r.s));
      check({name, "_carry"}, 65'(if8.carry), 65'(r.c));
    end
  endtask

  initial begin
    res8_t       last8;
    logic [63:0] ra;
    logic [63:0] rb;
    logic [64:0] e64;

    n_checks = 0;
    n_err    = 0;

    t1[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    t1[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    t1[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    t1[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    t1[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    t1[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    t1[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    t1[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    t8[0] = '{8'h00, 8'h00, 8'h00, 1'b0};
    t8[1] = '{8'h12, 8'h34, 8'h46, 1'b0};
    t8[2] = '{8'h7F, 8'h01, 8'h80, 1'b0};
    t8[3] = '{8'h80, 8'h7F, 8'hFF, 1'b0};
    t8[4] = '{8'hFF, 8'h01, 8'h00, 1'b1};
    t8[5] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};

    rst1  = 1'b0;
    rst8  = 1'b1;
    rst64 = 1'b1;
    if1.in_valid  = 1'b0; if1.a  = '0; if1.b  = '0;
    if8.in_valid  = 1'b0; if8.a  = '0; if8.b  = '0;
    if64.in_valid = 1'b0; if64.a = '0; if64.b = '0;

    // Combinational 1-bit path: same time step, independent of in_valid.
    for (int i = 0; i < 8; i++) begin
      if1.a = t1[i].a;
      if1.b = t1[i].b;
      if1.in_valid = t1[i].v;
      #1;
      check($sformatf("w1_sum_%0d", i), 65'(if1.sum), 65'(t1[i].s));
      check($sformatf("w1_carry_%0d", i), 65'(if1.carry), 65'(t1[i].c));
      check($sformatf("w1_valid_%0d", i), 65'(if1.out_valid), 65'(t1[i].v));
    end

    // Reset does not touch the combinational data path.
    @(negedge clk);
    rst1 = 1'b1; if1.a = 1'b1; if1.b = 1'b1; if1.in_valid = 1'b1;
    @(posedge clk); #1;
    check("w1_rst_sum", 65'(if1.sum), 65'd0);
    check("w1_rst_carry", 65'(if1.carry), 65'd1);
    check("w1_rst_valid", 65'(if1.out_valid), 65'd1);
    rst1 = 1'b0;

    // Reset held with a valid carry pair: pair dropped, outputs zero.
    @(negedge clk);
    rst8 = 1'b1; if8.in_valid = 1'b1; if8.a = 8'h80; if8.b = 8'h80;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check($sformatf("w8_rst_valid_%0d", i), 65'(if8.out_valid), 65'd0);
      check($sformatf("w8_rst_sum_%0d", i), 65'(if8.sum), 65'd0);
      check($sformatf("w8_rst_carry_%0d", i), 65'(if8.carry), 65'd0);
      check($sformatf("w64_rst_valid_%0d", i), 65'(if64.out_valid), 65'd0);
      check($sformatf("w64_rst_sum_%0d", i), 65'(if64.sum), 65'd0);
    end
    @(negedge clk);
    rst8 = 1'b0;
    rst64 = 1'b0;
    sb8.push_back('{8'h00, 1'b1});
    @(posedge clk); #1;
    pop8("w8_first_after_rst");

    foreach (t8[i]) begin
      @(negedge clk);
      if8.in_valid = 1'b1; if8.a = t8[i].a; if8.b = t8[i].b;
      last8 = '{t8[i].s, t8[i].c};
      sb8.push_back(last8);
      @(posedge clk); #1;
      pop8($sformatf("w8_vec_%0d", i));
    end

    // Idle cycles: out_valid drops, registered result holds.
    @(negedge clk);
    if8.in_valid = 1'b0; if8.a = 8'h12; if8.b = 8'h34;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check($sformatf("w8_hold_valid_%0d", i), 65'(if8.out_valid), 65'd0);
      check($sformatf("w8_hold_sum_%0d", i), 65'(if8.sum), 65'(last8.s));
      check($sformatf("w8_hold_carry_%0d", i), 65'(if8.carry), 65'(last8.c));
    end

    // 64-bit: all-ones first, then random pairs against a 65-bit reference.
    for (int i = 0; i < 10000; i++) begin
      if (i == 0) begin
        ra = '1;
        rb = '1;
      end else begin
        ra = {$urandom(), $urandom()};
        rb = {$urandom(), $urandom()};
      end
      @(negedge clk);
      if64.in_valid = 1'b1; if64.a = ra; if64.b = rb;
      sb64.push_back({1'b0, ra} + {1'b0, rb});
      @(posedge clk); #1;
      check("w64_valid", 65'(if64.out_valid), 65'd1);
      if (sb64.size() == 0) begin
        check("w64_sb_empty", 65'd1, 65'd0);
      end else begin
        e64 = sb64.pop_front();
        check($sformatf("w64_add_%0d", i), {if64.carry, if64.sum}, e64);
      end
    end
    @(negedge clk);
    if64.in_valid = 1'b0;

`ifdef HALF_ADDER_STATS_EN
    rst8 = 1'b1; if8.in_valid = 1'b1; if8.a = 8'hFF; if8.b = 8'h01;
    @(posedge clk); #1;
    check("cnt_rst", 65'(if8.carry_count), 65'd0);
    @(negedge clk);
    rst8 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: begin if8.in_valid = 1'b1; if8.a = 8'hFF; if8.b = 8'h01; end
        1: begin if8.in_valid = 1'b1; if8.a = 8'h01; if8.b = 8'h02; end
        2: begin if8.in_valid = 1'b1; if8.a = 8'h80; if8.b = 8'h80; end
        3: begin if8.in_valid = 1'b1; if8.a = 8'h10; if8.b = 8'h20; end
        4: begin if8.in_valid = 1'b1; if8.a = 8'hFF; if8.b = 8'hFF; end
        default: begin if8.in_valid = 1'b0; if8.a = 8'hFF; if8.b = 8'hFF; end
      endcase
      @(negedge clk);
    end
    check("cnt_three", 65'(if8.carry_count), 65'd3);
    if8.in_valid = 1'b1; if8.a = 8'hFF; if8.b = 8'hFF;
    repeat (65537) @(negedge clk);
    if8.in_valid = 1'b0;
    @(negedge clk);
    check("cnt_saturate", 65'(if8.carry_count), 65'hFFFF);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
